msrv32_dmem_ctrl: RTL and testbench
===================================

Name: msrv32_dmem_ctrl

Overview:
- Data-memory bus controller in the memory stage, directly upstream of the load unit.
- Takes load/store requests from the execute stage, aligns store data, and generates byte-lane write masks.
- Runs a registered single-outstanding bus transaction with wait-state handling, holding the pipeline stalled until it completes.
- Delivers registered read data, error response and load attributes (address offset, size, signedness) to the load unit.

Parameters:
- ADDR_W, 32, bus address width
- TIMEOUT_CYCLES, 16, wait-state limit before forced error; used only with the optional feature

Ports:
- clk_in  in  1  clock
- rst_in  in  1  synchronous, active-low reset
- mem_rd_req_in  in  1  load request, single-cycle pulse
- mem_wr_req_in  in  1  store request, single-cycle pulse
- iadder_in  in  ADDR_W  effective address
- rs2_in  in  32  store source data
- load_size_in  in  2  00 byte, 01 half, 10/11 word
- load_unsigned_in  in  1  zero-extend load
- ahb_ready_in  in  1  bus ready; 0 inserts a wait state
- ahb_resp_in  in  1  bus error response
- ahb_rdata_in  in  32  bus read data
- dmem_addr_out  out  ADDR_W  bus address, word-aligned ({addr[31:2],2'b00})
- dmem_wdata_out  out  32  lane-replicated store data
- dmem_wr_mask_out  out  4  byte enables
- dmem_req_out  out  1  transfer valid
- dmem_we_out  out  1  1 = write
- stall_out  out  1  pipeline stall
- misaligned_out  out  1  misaligned-access pulse
- lu_data_out  out  32  registered read data for the load unit
- lu_resp_out  out  1  registered bus error
- lu_valid_out  out  1  one-cycle completion pulse
- lu_iadder_1_to_0_out  out  2  captured addr[1:0]
- lu_load_size_out  out  2  captured size
- lu_load_unsigned_out  out  1  captured signedness

Behaviour:
- Reset (rst_in==0 at a clock edge):
  - State goes to IDLE.
  - Every output resets to 0.
  - Any in-flight transaction is dropped; no completion pulse follows.
- States: IDLE, BUSY, DONE.
- Request acceptance:
  - Requests are accepted only in IDLE or DONE.
  - If both mem_wr_req_in and mem_rd_req_in are high, the write wins and the read is ignored.
  - Requests arriving while BUSY are ignored; upstream holds them because stall_out is high.
- Alignment:
  - Half access with addr[0]=1, or word access with addr[1:0]!=0, is misaligned.
  - A misaligned request gets no bus transfer and stays in or returns to IDLE.
  - misaligned_out pulses high for exactly one cycle, the cycle after the request.
- Store formatting:
  - Byte: wdata={4{rs2[7:0]}}, mask=4'b0001<<addr[1:0].
  - Half: wdata={2{rs2[15:0]}}, mask=4'b0011<<{addr[1],1'b0}.
  - Word: wdata=rs2, mask=4'b1111.
  - Loads drive mask=4'b0000.
- IDLE/DONE + aligned request → BUSY:
  - Bus outputs (addr, wdata, mask, req=1, we) and the load attributes are registered on the accepting edge.
  - They hold constant for the whole of BUSY.
- BUSY:
  - stall_out=1.
  - ahb_ready_in==0: remain in BUSY with outputs unchanged.
  - ahb_ready_in==1: capture ahb_rdata_in into lu_data_out and ahb_resp_in into lu_resp_out, then go to DONE.
  - On a write completion, lu_data_out is loaded with 0.
- DONE:
  - Lasts one cycle: lu_valid_out=1, dmem_req_out=0, stall_out=0.
  - With a new aligned request → BUSY (back-to-back, no idle bubble); otherwise → IDLE.
- Latency: request at cycle 0, ready first seen high at cycle k≥1, completion pulse at cycle k+1. Minimum is 2 cycles.
- lu_data_out and lu_resp_out hold their value until the next completion.

Optional Feature:
- Macro MSRV32_DMEM_TIMEOUT_EN.
- When defined:
  - A wait-state counter (clog2(TIMEOUT_CYCLES+1) bits) clears on entry to BUSY and increments each BUSY cycle with ready low.
  - When the counter reaches TIMEOUT_CYCLES, the transfer is abandoned: lu_resp_out=1, lu_data_out=0, state goes to DONE, dmem_req_out drops.
  - A ready arriving in the same cycle the counter reaches the limit takes priority and completes normally.
- When undefined: no counter; BUSY waits indefinitely.

Decomposition:
- Shared package msrv32_pkg holds:
  - the state encoding (IDLE/BUSY/DONE)
  - load_size codes (LS_BYTE, LS_HALF, LS_WORD)
  - a WORD_W=32 constant
- One natural sub-module, msrv32_store_align: a combinational misalignment check plus wdata/mask formatter; the FSM and registers stay in the top level.

Test Plan:
- Store byte: iadder=0x1003, rs2=0xAABBCCDD, ready=1 → next cycle addr=0x1000, wdata=0xDDDDDDDD, mask=4'b1000, we=1; lu_valid pulse 2 cycles after the request.
- Load word with 3 wait states: addr 0x2000, ready low for 3 cycles, rdata=0x12345678 → stall high for 4 cycles; lu_data_out=0x12345678 and lu_valid high in cycle 5.
- Misaligned: half at 0x1001 → misaligned_out pulses once, dmem_req_out stays 0, stall_out stays 0.
- Bus error: load with ahb_resp_in=1 at ready → lu_resp_out=1 with lu_valid; the next clean load clears lu_resp_out to 0.
- Back-to-back and reset: new load presented during DONE → enters BUSY with no idle cycle; rst_in low mid-BUSY → all outputs 0 next edge and no lu_valid pulse.
- Timeout (MSRV32_DMEM_TIMEOUT_EN, TIMEOUT_CYCLES=4): ready held low → lu_resp_out=1, lu_data_out=0, lu_valid after 4 wait cycles; ready rising on cycle 4 completes normally instead.

Source files
------------

// File: rtl/msrv32_pkg.sv
// rtl/msrv32_pkg.sv - shared encodings for the data-memory controller
// State codes, load/store size codes and the data word width.
package msrv32_pkg;

  localparam int WORD_W = 32;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_DONE = 2'd2
  } dmem_state_e;

  localparam logic [1:0] LS_BYTE = 2'b00;
  localparam logic [1:0] LS_HALF = 2'b01;
  localparam logic [1:0] LS_WORD = 2'b10;

endpackage

// File: rtl/msrv32_store_align.sv
// rtl/msrv32_store_align.sv - misalignment check and store lane formatter
// Purely combinational; size codes 10 and 11 both mean word.
module msrv32_store_align
  import msrv32_pkg::*;
(
  input  logic [1:0]        addr_lo_in,
  input  logic [1:0]        size_in,
  input  logic [WORD_W-1:0] rs2_in,
  output logic              misaligned_out,
  output logic [WORD_W-1:0] wdata_out,
  output logic [3:0]        mask_out
);

  always_comb begin
    misaligned_out = 1'b0;
    wdata_out      = rs2_in;
    mask_out       = 4'b1111;
    if (size_in == LS_BYTE) begin
      wdata_out = {4{rs2_in[7:0]}};
      mask_out  = 4'b0001 << addr_lo_in;
    end else if (size_in == LS_HALF) begin
      wdata_out      = {2{rs2_in[15:0]}};
      mask_out       = 4'b0011 << {addr_lo_in[1], 1'b0};
      misaligned_out = addr_lo_in[0];
    end else begin
      misaligned_out = (addr_lo_in != 2'b00);
    end
  end

endmodule

// File: rtl/msrv32_dmem_ctrl.sv
// rtl/msrv32_dmem_ctrl.sv - data-memory bus controller, single outstanding transfer
// Define MSRV32_DMEM_TIMEOUT_EN to abandon transfers stuck in wait states.
module msrv32_dmem_ctrl
  import msrv32_pkg::*;
#(
  parameter int ADDR_W         = 32,
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic              clk_in,
  input  logic              rst_in,
  input  logic              mem_rd_req_in,
  input  logic              mem_wr_req_in,
  input  logic [ADDR_W-1:0] iadder_in,
  input  logic [WORD_W-1:0] rs2_in,
  input  logic [1:0]        load_size_in,
  input  logic              load_unsigned_in,
  input  logic              ahb_ready_in,
  input  logic              ahb_resp_in,
  input  logic [WORD_W-1:0] ahb_rdata_in,
  output logic [ADDR_W-1:0] dmem_addr_out,
  output logic [WORD_W-1:0] dmem_wdata_out,
  output logic [3:0]        dmem_wr_mask_out,
  output logic              dmem_req_out,
  output logic              dmem_we_out,
  output logic              stall_out,
  output logic              misaligned_out,
  output logic [WORD_W-1:0] lu_data_out,
  output logic              lu_resp_out,
  output logic              lu_valid_out,
  output logic [1:0]        lu_iadder_1_to_0_out,
  output logic [1:0]        lu_load_size_out,
  output logic              lu_load_unsigned_out
);

  dmem_state_e       state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [WORD_W-1:0] wdata_q, wdata_d;
  logic [3:0]        mask_q, mask_d;
  logic              req_q, req_d;
  logic              we_q, we_d;
  logic              mis_q, mis_d;
  logic [WORD_W-1:0] lu_data_q, lu_data_d;
  logic              lu_resp_q, lu_resp_d;
  logic              lu_valid_q, lu_valid_d;
  logic [1:0]        lu_off_q, lu_off_d;
  logic [1:0]        lu_size_q, lu_size_d;
  logic              lu_uns_q, lu_uns_d;

  logic              align_mis;
  logic [WORD_W-1:0] align_wdata;
  logic [3:0]        align_mask;

  msrv32_store_align u_align (
    .addr_lo_in     (iadder_in[1:0]),
    .size_in        (load_size_in),
    .rs2_in         (rs2_in),
    .misaligned_out (align_mis),
    .wdata_out      (align_wdata),
    .mask_out       (align_mask)
  );

`ifdef MSRV32_DMEM_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
  logic [CNT_W-1:0] wait_cnt_q, wait_cnt_d;
`else
  logic unused_timeout_cfg;
  assign unused_timeout_cfg = (TIMEOUT_CYCLES != 0);
`endif

  always_comb begin
    state_d    = state_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    mask_d     = mask_q;
    req_d      = req_q;
    we_d       = we_q;
    mis_d      = 1'b0;
    lu_data_d  = lu_data_q;
    lu_resp_d  = lu_resp_q;
    lu_valid_d = 1'b0;
    lu_off_d   = lu_off_q;
    lu_size_d  = lu_size_q;
    lu_uns_d   = lu_uns_q;
`ifdef MSRV32_DMEM_TIMEOUT_EN
    wait_cnt_d = wait_cnt_q;
`endif
    case (state_q)
      ST_BUSY: begin
        if (ahb_ready_in) begin
          lu_data_d  = we_q ? '0 : ahb_rdata_in;
          lu_resp_d  = ahb_resp_in;
          req_d      = 1'b0;
          we_d       = 1'b0;
          lu_valid_d = 1'b1;
          state_d    = ST_DONE;
        end
`ifdef MSRV32_DMEM_TIMEOUT_EN
        // A ready in the limit cycle is handled above and completes normally.
        else if (wait_cnt_q == CNT_LAST) begin
          lu_data_d  = '0;
          lu_resp_d  = 1'b1;
          req_d      = 1'b0;
          we_d       = 1'b0;
          lu_valid_d = 1'b1;
          state_d    = ST_DONE;
        end else begin
          wait_cnt_d = wait_cnt_q + 1'b1;
        end
`endif
      end
      default: begin
        state_d = ST_IDLE;
        // Write wins when both request pulses arrive together.
        if (mem_wr_req_in || mem_rd_req_in) begin
          if (align_mis) begin
            mis_d = 1'b1;
          end else begin
            addr_d    = {iadder_in[ADDR_W-1:2], 2'b00};
            wdata_d   = mem_wr_req_in ? align_wdata : '0;
            mask_d    = mem_wr_req_in ? align_mask : 4'b0000;
            req_d     = 1'b1;
            we_d      = mem_wr_req_in;
            lu_off_d  = iadder_in[1:0];
            lu_size_d = load_size_in;
            lu_uns_d  = load_unsigned_in;
            state_d   = ST_BUSY;
`ifdef MSRV32_DMEM_TIMEOUT_EN
            wait_cnt_d = '0;
`endif
          end
        end
      end
    endcase
  end

  always_ff @(posedge clk_in) begin
    if (!rst_in) begin
      state_q    <= ST_IDLE;
      addr_q     <= '0;
      wdata_q    <= '0;
      mask_q     <= '0;
      req_q      <= 1'b0;
      we_q       <= 1'b0;
      mis_q      <= 1'b0;
      lu_data_q  <= '0;
      lu_resp_q  <= 1'b0;
      lu_valid_q <= 1'b0;
      lu_off_q   <= '0;
      lu_size_q  <= '0;
      lu_uns_q   <= 1'b0;
`ifdef MSRV32_DMEM_TIMEOUT_EN
      wait_cnt_q <= '0;
`endif
    end else begin
      state_q    <= state_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      mask_q     <= mask_d;
      req_q      <= req_d;
      we_q       <= we_d;
      mis_q      <= mis_d;
      lu_data_q  <= lu_data_d;
      lu_resp_q  <= lu_resp_d;
      lu_valid_q <= lu_valid_d;
      lu_off_q   <= lu_off_d;
      lu_size_q  <= lu_size_d;
      lu_uns_q   <= lu_uns_d;
`ifdef MSRV32_DMEM_TIMEOUT_EN
      wait_cnt_q <= wait_cnt_d;
`endif
    end
  end

  assign dmem_addr_out        = addr_q;
  assign dmem_wdata_out       = wdata_q;
  assign dmem_wr_mask_out     = mask_q;
  assign dmem_req_out         = req_q;
  assign dmem_we_out          = we_q;
  assign stall_out            = (state_q == ST_BUSY);
  assign misaligned_out       = mis_q;
  assign lu_data_out          = lu_data_q;
  assign lu_resp_out          = lu_resp_q;
  assign lu_valid_out         = lu_valid_q;
  assign lu_iadder_1_to_0_out = lu_off_q;
  assign lu_load_size_out     = lu_size_q;
  assign lu_load_unsigned_out = lu_uns_q;

endmodule

// File: tb/tb_msrv32_dmem_ctrl.sv
// tb/tb_msrv32_dmem_ctrl.sv - self-checking bench for msrv32_dmem_ctrl
// Directed test-plan steps followed by randomized transfers against a transaction-level model.
module tb_msrv32_dmem_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        rd_req, wr_req;
  logic [31:0] iadder, rs2;
  logic [1:0]  size;
  logic        uns;
  logic        ready, resp;
  logic [31:0] rdata;
  logic [31:0] d_addr, d_wdata, lu_data;
  logic [3:0]  d_mask;
  logic        d_req, d_we, stall, mis, lu_resp, lu_valid, lu_uns;
  logic [1:0]  lu_off, lu_size;

  int          checks = 0;
  int          failures = 0;
  logic [31:0] last_data;
  logic        last_resp;

  always #5 clk = ~clk;

  msrv32_dmem_ctrl #(.ADDR_W(32), .TIMEOUT_CYCLES(4)) dut (
    .clk_in               (clk),
    .rst_in               (rst_n),
    .mem_rd_req_in        (rd_req),
    .mem_wr_req_in        (wr_req),
    .iadder_in            (iadder),
    .rs2_in               (rs2),
    .load_size_in         (size),
    .load_unsigned_in     (uns),
    .ahb_ready_in         (ready),
    .ahb_resp_in          (resp),
    .ahb_rdata_in         (rdata),
    .dmem_addr_out        (d_addr),
    .dmem_wdata_out       (d_wdata),
    .dmem_wr_mask_out     (d_mask),
    .dmem_req_out         (d_req),
    .dmem_we_out          (d_we),
    .stall_out            (stall),
    .misaligned_out       (mis),
    .lu_data_out          (lu_data),
    .lu_resp_out          (lu_resp),
    .lu_valid_out         (lu_valid),
    .lu_iadder_1_to_0_out (lu_off),
    .lu_load_size_out     (lu_size),
    .lu_load_unsigned_out (lu_uns)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed %h, expected %h", tag, obs, exp);
    end
  endtask

  function automatic int nbytes(input logic [1:0] sz);
    return (sz == 2'd0) ? 1 : (sz == 2'd1) ? 2 : 4;
  endfunction

  function automatic logic [3:0] exp_mask(input logic [31:0] a, input logic [1:0] sz);
    int nb;
    nb = nbytes(sz);
    if (nb == 4) return 4'hF;
    return 4'(((1 << nb) - 1) << (a % 4));
  endfunction

  function automatic logic [31:0] exp_wdata(input logic [31:0] d, input logic [1:0] sz);
    int nb;
    nb = nbytes(sz);
    if (nb == 1) return {24'd0, d[7:0]} * 32'h01010101;
    if (nb == 2) return {16'd0, d[15:0]} * 32'h00010001;
    return d;
  endfunction

  task automatic chk_all_zero(input string tag);
    chk({tag, "_addr"}, d_addr, 0);
    chk({tag, "_wdata"}, d_wdata, 0);
    chk({tag, "_mask"}, {28'd0, d_mask}, 0);
    chk({tag, "_ctl"}, {27'd0, d_req, d_we, stall, mis, lu_valid}, 0);
    chk({tag, "_lu_data"}, lu_data, 0);
    chk({tag, "_lu_attr"}, {26'd0, lu_resp, lu_off, lu_size, lu_uns}, 0);
  endtask

  task automatic idle();
    @(negedge clk);
    chk("idle_ctl", {28'd0, d_req, stall, mis, lu_valid}, 0);
    chk("idle_hold_data", lu_data, last_data);
    chk("idle_hold_resp", {31'd0, lu_resp}, {31'd0, last_resp});
  endtask

  // Entered and left at a negedge; on return the DUT shows the completion cycle.
  task automatic txn(input bit wr, input logic [31:0] a, input logic [31:0] d,
                     input logic [1:0] sz, input bit u, input int waits,
                     input bit rsp, input logic [31:0] rd);
    bit misal;
    misal  = (a % nbytes(sz)) != 0;
    wr_req = wr;
    rd_req = wr ? 1'($urandom_range(0, 1)) : 1'b1;
    iadder = a; rs2 = d; size = sz; uns = u;
    ready  = 1'($urandom_range(0, 1));
    @(negedge clk);
    wr_req = 1'b0; rd_req = 1'b0;
    if (misal) begin
      chk("mis_pulse", {31'd0, mis}, 1);
      chk("mis_noreq", {30'd0, d_req, stall}, 0);
      ready = 1'b0;
    end else begin
      chk("no_mis", {31'd0, mis}, 0);
      for (int i = 1; i <= waits + 1; i++) begin
        chk("busy_ctl", {28'd0, stall, d_req, d_we, lu_valid}, {28'd0, 1'b1, 1'b1, wr, 1'b0});
        chk("busy_addr", d_addr, a & 32'hFFFF_FFFC);
        chk("busy_mask", {28'd0, d_mask}, wr ? {28'd0, exp_mask(a, sz)} : 32'd0);
        if (wr) chk("busy_wdata", d_wdata, exp_wdata(d, sz));
        chk("busy_attr", {27'd0, lu_off, lu_size, lu_uns}, {27'd0, a[1:0], sz, u});
        ready  = (i == waits + 1);
        resp   = ready ? rsp : 1'($urandom_range(0, 1));
        rdata  = ready ? rd : $urandom;
        rd_req = (i <= waits) ? 1'($urandom_range(0, 1)) : 1'b0;
        wr_req = (i <= waits) ? 1'($urandom_range(0, 1)) : 1'b0;
        @(negedge clk);
      end
      rd_req = 1'b0; wr_req = 1'b0; ready = 1'b0;
      last_data = wr ? 32'd0 : rd;
      last_resp = rsp;
      chk("done_ctl", {28'd0, lu_valid, stall, d_req, mis}, {28'd0, 4'b1000});
      chk("done_data", lu_data, last_data);
      chk("done_resp", {31'd0, lu_resp}, {31'd0, last_resp});
      chk("done_attr", {27'd0, lu_off, lu_size, lu_uns}, {27'd0, a[1:0], sz, u});
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    rst_n = 1'b0; rd_req = 1'b0; wr_req = 1'b0; iadder = '0; rs2 = '0;
    size = '0; uns = 1'b0; ready = 1'b0; resp = 1'b0; rdata = '0;
    last_data = '0; last_resp = 1'b0;
    repeat (3) @(negedge clk);
    chk_all_zero("reset");
    rst_n = 1'b1;
    idle();

    txn(1'b1, 32'h1003, 32'hAABBCCDD, 2'd0, 1'b0, 0, 1'b0, 32'h0);
    idle();
    txn(1'b0, 32'h2000, 32'h0, 2'd2, 1'b0, 3, 1'b0, 32'h12345678);
    idle();
    txn(1'b0, 32'h1001, 32'h0, 2'd1, 1'b0, 0, 1'b0, 32'h0);
    idle();
    txn(1'b0, 32'h4004, 32'h0, 2'd2, 1'b1, 1, 1'b1, 32'hDEADBEEF);
    txn(1'b0, 32'h4008, 32'h0, 2'd1, 1'b1, 0, 1'b0, 32'h0000CAFE);
    txn(1'b1, 32'h400A, 32'h11223344, 2'd1, 1'b0, 2, 1'b0, 32'h0);
    idle();

    // Reset in the middle of a wait-stated load.
    rd_req = 1'b1; iadder = 32'h5000; size = 2'd2; ready = 1'b0;
    @(negedge clk);
    rd_req = 1'b0;
    chk("pre_rst_stall", {31'd0, stall}, 1);
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    chk_all_zero("mid_rst");
    rst_n = 1'b1;
    last_data = '0; last_resp = 1'b0;
    repeat (3) idle();

`ifdef MSRV32_DMEM_TIMEOUT_EN
    rd_req = 1'b1; iadder = 32'h3000; size = 2'd2; ready = 1'b0;
    @(negedge clk);
    rd_req = 1'b0;
    for (int i = 1; i <= 4; i++) begin
      chk("to_wait", {30'd0, stall, lu_valid}, 32'd2);
      @(negedge clk);
    end
    last_data = '0; last_resp = 1'b1;
    chk("to_done", {29'd0, lu_valid, stall, lu_resp}, 32'd5);
    chk("to_data", lu_data, 0);
    txn(1'b0, 32'h3004, 32'h0, 2'd2, 1'b0, 3, 1'b0, 32'h0BADF00D);
    idle();
`endif

    for (int n = 0; n < 40; n++) begin
      txn(1'($urandom_range(0, 1)), $urandom, $urandom, 2'($urandom_range(0, 3)),
          1'($urandom_range(0, 1)), $urandom_range(0, 3), ($urandom_range(0, 5) == 0),
          $urandom);
      if ($urandom_range(0, 1) == 1) idle();
    end
    idle();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
